// File: rtl/wb_test_slave.sv
// wb_test_slave: Wishbone B4 test responder with a small word RAM,
// programmable wait states and registered-feedback bursts.
module wb_test_slave #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       DEPTH         = 16,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       WAIT_STATES   = 1
) (
  input  logic                     WB_CLK_I,
  input  logic                     WB_RST_I,
  input  logic [WB_ADDR_WIDTH-1:0] WB_ADR_I,
  input  logic [WB_DATA_WIDTH-1:0] WB_DAT_I,
  output logic [WB_DATA_WIDTH-1:0] WB_DAT_O,
  input  logic                     WB_WE_I,
  input  logic                     WB_STB_I,
  input  logic                     WB_CYC_I,
  input  logic [2:0]               WB_CTI_I,
  output logic                     WB_ACK_O,
  output logic                     WB_ERR_O,
  output logic                     WB_RTY_O,
  output logic                     WB_STALL_O
);

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 32;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_BURST
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_ack_q;
  logic          w_ack_nxt;
  logic          r_err_q;
  logic          w_err_nxt;
  logic [AW-1:0] r_adr;
  logic [AW-1:0] w_adr_nxt;
  logic          r_we;
  logic          w_we_nxt;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] w_dat_nxt;
  logic          r_inr;
  logic          w_inr_nxt;
  logic [DW-1:0] r_dat_o;
  logic [DW-1:0] w_dat_o_nxt;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_req;
  logic          w_bus_inr;
  logic          w_cti_more;
  logic [AW-1:0] w_nadr;
  logic          w_nadr_inr;
  logic          w_go;
  logic [AW-1:0] w_go_adr;
  logic          w_go_we;
  logic [DW-1:0] w_go_dat;
  logic          w_go_inr;
  logic [IW-1:0] w_go_idx;
  logic          w_mem_we;

  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE_ADDR;
    return CW'(off) < CW'(unsigned'(DEPTH));
  endfunction

  assign w_req      = WB_STB_I & WB_CYC_I;
  assign w_bus_inr  = in_range(WB_ADR_I);
  assign w_cti_more = (WB_CTI_I == 3'b001) || (WB_CTI_I == 3'b010);
  assign w_nadr     = (WB_CTI_I == 3'b001) ? r_adr : r_adr + 1'b1;
  assign w_nadr_inr = in_range(w_nadr);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = r_ack_q;
    w_err_nxt   = r_err_q;
    w_adr_nxt   = r_adr;
    w_we_nxt    = r_we;
    w_dat_nxt   = r_dat;
    w_inr_nxt   = r_inr;
    w_dat_o_nxt = r_dat_o;
    w_go        = 1'b0;
    w_go_adr    = r_adr;
    w_go_we     = r_we;
    w_go_dat    = r_dat;
    w_go_inr    = r_inr;
    if (!WB_CYC_I) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_dat_o_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            w_adr_nxt = WB_ADR_I;
            w_we_nxt  = WB_WE_I;
            w_dat_nxt = WB_DAT_I;
            w_inr_nxt = w_bus_inr;
            if (WS == 4'd0) begin
              w_state_nxt = S_RESP;
              w_go        = 1'b1;
              w_go_adr    = WB_ADR_I;
              w_go_we     = WB_WE_I;
              w_go_dat    = WB_DAT_I;
              w_go_inr    = w_bus_inr;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = WS;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RESP;
            w_go        = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        S_RESP, S_BURST: begin
          // Next beat is taken speculatively on the edge ending this one.
          if (w_req && !r_err_q && w_cti_more) begin
            w_state_nxt = S_BURST;
            w_adr_nxt   = w_nadr;
            w_we_nxt    = WB_WE_I;
            w_dat_nxt   = WB_DAT_I;
            w_inr_nxt   = w_nadr_inr;
            w_go        = 1'b1;
            w_go_adr    = w_nadr;
            w_go_we     = WB_WE_I;
            w_go_dat    = WB_DAT_I;
            w_go_inr    = w_nadr_inr;
          end else begin
            w_state_nxt = S_IDLE;
            w_ack_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
            w_dat_o_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
    if (w_go) begin
      w_ack_nxt   = w_go_inr;
      w_err_nxt   = !w_go_inr;
      w_dat_o_nxt = (w_go_inr && !w_go_we) ? r_mem[w_go_idx] : '0;
    end
  end

  assign w_go_idx = IW'(w_go_adr - BASE_ADDR);
  assign w_mem_we = w_go & w_go_inr & w_go_we & !WB_RST_I;

  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack_q <= 1'b0;
      r_err_q <= 1'b0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_inr   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack_q <= w_ack_nxt;
      r_err_q <= w_err_nxt;
      r_adr   <= w_adr_nxt;
      r_we    <= w_we_nxt;
      r_dat   <= w_dat_nxt;
      r_inr   <= w_inr_nxt;
      r_dat_o <= w_dat_o_nxt;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge WB_CLK_I) begin
    if (w_mem_we) begin
      r_mem[w_go_idx] <= w_go_dat;
    end
  end

  assign WB_DAT_O   = r_dat_o;
  assign WB_ACK_O   = r_ack_q & w_req;
  assign WB_ERR_O   = r_err_q & w_req;
  assign WB_RTY_O   = 1'b0;
  assign WB_STALL_O = (r_state == S_WAIT);

endmodule
